// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: opcodes, ALU control codes and the datapath width.
// The ALU imports the same codes, so both ends of the interface always agree.
package riscv_pkg;

  localparam int TAMANYO = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b01000;
  localparam logic [4:0] ALU_SLTU = 5'b01100;
  localparam logic [4:0] ALU_XOR  = 5'b10000;
  localparam logic [4:0] ALU_SRL  = 5'b10100;
  localparam logic [4:0] ALU_SRA  = 5'b10110;
  localparam logic [4:0] ALU_OR   = 5'b11000;
  localparam logic [4:0] ALU_AND  = 5'b11100;
  localparam logic [4:0] ALU_BGE  = 5'b11010;
  localparam logic [4:0] ALU_BGEU = 5'b11110;
  localparam logic [4:0] ALU_LUI  = 5'b11111;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
  } ex_ctrl_t;

  // A later stage supplies a register value only if it writes a non-x0 destination matching rs.
  function automatic logic fwd_hit(input logic [4:0] src_rd, input logic src_we, input logic [4:0] rs);
    return src_we && (src_rd != 5'd0) && (src_rd == rs);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into the ALU control code.
// known_op is low for opcodes this core does not implement.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [4:0] alu_control,
  output logic       known_op
);

  // For I-type, funct7[5] is an immediate bit except on shifts, so ADDI never becomes SUB.
  always_comb begin
    alu_control = ALU_ADD;
    known_op    = 1'b1;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3)
          3'b000:  alu_control = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_control = ALU_SUB;
          3'b100:         alu_control = ALU_SLT;
          3'b101:         alu_control = ALU_BGE;
          3'b110:         alu_control = ALU_SLTU;
          3'b111:         alu_control = ALU_BGEU;
          default:        alu_control = ALU_ADD;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_AUIPC: alu_control = ALU_ADD;
      OPC_LUI: alu_control = ALU_LUI;
      default: known_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, operand selection and
// load-use hazard detection; A/B/ALU_control feed the ALU directly.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int tamanyo = TAMANYO
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               id_valid,
  input  logic [tamanyo-1:0] id_pc,
  input  logic [tamanyo-1:0] id_rs1_data,
  input  logic [tamanyo-1:0] id_rs2_data,
  input  logic [tamanyo-1:0] id_imm,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [4:0]         id_rd,
  input  logic [6:0]         id_opcode,
  input  logic [2:0]         id_funct3,
  input  logic               id_funct7_5,
  input  logic [4:0]         exmem_rd,
  input  logic               exmem_regwrite,
  input  logic [tamanyo-1:0] exmem_result,
  input  logic [4:0]         memwb_rd,
  input  logic               memwb_regwrite,
  input  logic [tamanyo-1:0] memwb_result,
  input  logic               stall,
  input  logic               flush,
  output logic [tamanyo-1:0] A,
  output logic [tamanyo-1:0] B,
  output logic [4:0]         ALU_control,
  output logic               ex_valid,
  output logic [4:0]         ex_rd,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_branch,
  output logic [2:0]         ex_funct3,
  output logic [tamanyo-1:0] ex_pc,
  output logic [tamanyo-1:0] ex_store_data,
  output logic               load_use_hazard
);

  typedef struct packed {
    logic               valid;
    ex_ctrl_t           ctrl;
    logic [4:0]         alu_control;
    a_sel_e             a_sel;
    b_sel_e             b_sel;
    logic [tamanyo-1:0] pc;
    logic [tamanyo-1:0] rs1_data;
    logic [tamanyo-1:0] rs2_data;
    logic [tamanyo-1:0] imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [2:0]         funct3;
  } stage_t;

  stage_t             stage_d;
  stage_t             stage_q;
  logic [4:0]         dec_alu;
  logic               dec_known;
  logic [tamanyo-1:0] rs1_fwd;
  logic [tamanyo-1:0] rs2_fwd;

  alu_decoder u_alu_decoder (
    .opcode      (id_opcode),
    .funct3      (id_funct3),
    .funct7_5    (id_funct7_5),
    .alu_control (dec_alu),
    .known_op    (dec_known)
  );

  always_comb begin
    stage_d               = '0;
    stage_d.valid         = 1'b1;
    stage_d.alu_control   = dec_alu;
    stage_d.pc            = id_pc;
    stage_d.rs1_data      = id_rs1_data;
    stage_d.rs2_data      = id_rs2_data;
    stage_d.imm           = id_imm;
    stage_d.rs1           = id_rs1;
    stage_d.rs2           = id_rs2;
    stage_d.rd            = id_rd;
    stage_d.funct3        = id_funct3;
    stage_d.ctrl.regwrite = dec_known && (id_opcode != OPC_STORE) && (id_opcode != OPC_BRANCH);
    stage_d.ctrl.memread  = (id_opcode == OPC_LOAD);
    stage_d.ctrl.memwrite = (id_opcode == OPC_STORE);
    stage_d.ctrl.branch   = (id_opcode == OPC_BRANCH);
    case (id_opcode)
      OPC_AUIPC, OPC_JAL: stage_d.a_sel = A_PC;
      OPC_LUI:            stage_d.a_sel = A_ZERO;
      default:            stage_d.a_sel = A_RS1;
    endcase
    case (id_opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC: stage_d.b_sel = B_IMM;
      OPC_JAL, OPC_JALR:                                   stage_d.b_sel = B_FOUR;
      default:                                             stage_d.b_sel = B_RS2;
    endcase
  end

  // Bubbles clear the whole register, so stale operands never reach the ALU.
  always_ff @(posedge CLK) begin
    if (RSTa || flush || (!stall && !id_valid)) begin
      stage_q <= '0;
    end else if (!stall) begin
      stage_q <= stage_d;
    end
  end

  // Forwarding stays live during a stall so a held instruction picks up late results.
  always_comb begin
    rs1_fwd = stage_q.rs1_data;
    if (fwd_hit(exmem_rd, exmem_regwrite, stage_q.rs1)) begin
      rs1_fwd = exmem_result;
    end else if (fwd_hit(memwb_rd, memwb_regwrite, stage_q.rs1)) begin
      rs1_fwd = memwb_result;
    end
    rs2_fwd = stage_q.rs2_data;
    if (fwd_hit(exmem_rd, exmem_regwrite, stage_q.rs2)) begin
      rs2_fwd = exmem_result;
    end else if (fwd_hit(memwb_rd, memwb_regwrite, stage_q.rs2)) begin
      rs2_fwd = memwb_result;
    end
    case (stage_q.a_sel)
      A_PC:    A = stage_q.pc;
      A_ZERO:  A = '0;
      default: A = rs1_fwd;
    endcase
    case (stage_q.b_sel)
      B_IMM:   B = stage_q.imm;
      B_FOUR:  B = tamanyo'(4);
      default: B = rs2_fwd;
    endcase
  end

  assign ALU_control   = stage_q.alu_control;
  assign ex_valid      = stage_q.valid;
  assign ex_rd         = stage_q.rd;
  assign ex_regwrite   = stage_q.ctrl.regwrite;
  assign ex_memread    = stage_q.ctrl.memread;
  assign ex_memwrite   = stage_q.ctrl.memwrite;
  assign ex_branch     = stage_q.ctrl.branch;
  assign ex_funct3     = stage_q.funct3;
  assign ex_pc         = stage_q.pc;
  assign ex_store_data = rs2_fwd;

  assign load_use_hazard = stage_q.valid && stage_q.ctrl.memread && (stage_q.rd != 5'd0) &&
                           id_valid && ((stage_q.rd == id_rs1) || (stage_q.rd == id_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written stall/flush/reset
// sequences, then random traffic checked against a mnemonic-level model.
module tb_id_ex_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
  } instr_t;

  typedef struct {
    string       name;
    instr_t      ins;
    logic [4:0]  xrd;
    logic        xwe;
    logic [31:0] xres;
    logic [4:0]  mrd;
    logic        mwe;
    logic [31:0] mres;
    logic        chk_ab;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [4:0]  exp_alu;
    logic        exp_rw;
    logic        exp_br;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RSTa, id_valid, id_funct7_5, exmem_regwrite, memwb_regwrite, stall, flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
  logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [31:0] A, B, ex_pc, ex_store_data;
  logic [4:0]  ALU_control, ex_rd;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, load_use_hazard;
  logic [2:0]  ex_funct3;

  int checks = 0;
  int errors = 0;
  logic [4:0] code_tbl[string];
  instr_t held, held_next;
  vec_t vecs[$];
  logic [6:0] op_list[10] = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                              OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI, 7'h7F};

  always #5 CLK = ~CLK;

  id_ex_stage #(.tamanyo(32)) dut (
    .CLK(CLK), .RSTa(RSTa), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .stall(stall), .flush(flush), .A(A), .B(B), .ALU_control(ALU_control),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
    .load_use_hazard(load_use_hazard)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input instr_t ins, input logic st, input logic fl, input logic rst);
    id_valid    = ins.valid;
    id_pc       = ins.pc;
    id_rs1_data = ins.rs1d;
    id_rs2_data = ins.rs2d;
    id_imm      = ins.imm;
    id_rs1      = ins.rs1;
    id_rs2      = ins.rs2;
    id_rd       = ins.rd;
    id_opcode   = ins.op;
    id_funct3   = ins.f3;
    id_funct7_5 = ins.f75;
    stall       = st;
    flush       = fl;
    RSTa        = rst;
  endtask

  task automatic setForward(input logic [4:0] xrd, input logic xwe, input logic [31:0] xres,
                            input logic [4:0] mrd, input logic mwe, input logic [31:0] mres);
    exmem_rd = xrd; exmem_regwrite = xwe; exmem_result = xres;
    memwb_rd = mrd; memwb_regwrite = mwe; memwb_result = mres;
  endtask

  function automatic instr_t mkIns(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                   input logic [4:0] rs1, input logic [31:0] rs1d,
                                   input logic [4:0] rs2, input logic [31:0] rs2d,
                                   input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
    instr_t i;
    i.valid = 1'b1; i.op = op; i.f3 = f3; i.f75 = f75;
    i.rs1 = rs1; i.rs1d = rs1d; i.rs2 = rs2; i.rs2d = rs2d;
    i.rd = rd; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic vec_t mkVec(input string name, input instr_t ins,
                                 input logic [4:0] xrd, input logic xwe, input logic [31:0] xres,
                                 input logic [4:0] mrd, input logic mwe, input logic [31:0] mres,
                                 input logic chk_ab, input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [4:0] ealu, input logic erw, input logic ebr);
    vec_t v;
    v.name = name; v.ins = ins; v.xrd = xrd; v.xwe = xwe; v.xres = xres;
    v.mrd = mrd; v.mwe = mwe; v.mres = mres; v.chk_ab = chk_ab;
    v.exp_a = ea; v.exp_b = eb; v.exp_alu = ealu; v.exp_rw = erw; v.exp_br = ebr;
    return v;
  endfunction

  function automatic string opClass(input logic [6:0] op);
    case (op)
      OPC_OP:     return "R";
      OPC_OP_IMM: return "I";
      OPC_LOAD:   return "LOAD";
      OPC_STORE:  return "STORE";
      OPC_BRANCH: return "BR";
      OPC_JAL:    return "JAL";
      OPC_JALR:   return "JALR";
      OPC_AUIPC:  return "AUIPC";
      OPC_LUI:    return "LUI";
      default:    return "UNK";
    endcase
  endfunction

  function automatic string mnemonic(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    string alu_names[8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    string br_names[8]  = '{"BEQ", "BNE", "BXX", "BXX", "BLT", "BGE", "BLTU", "BGEU"};
    string c;
    c = opClass(op);
    if (c == "R" || c == "I") begin
      if (c == "R" && f3 == 3'd0 && f75) return "SUB";
      if (f3 == 3'd5 && f75) return "SRA";
      return alu_names[f3];
    end
    if (c == "BR") return br_names[f3];
    return c;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] own);
    if (idx != 0 && exmem_regwrite && exmem_rd == idx) return exmem_result;
    if (idx != 0 && memwb_regwrite && memwb_rd == idx) return memwb_result;
    return own;
  endfunction

  task automatic checkModel(input instr_t h);
    string c, m;
    logic [31:0] f1, f2, ea, eb;
    logic hz, rw;
    c  = opClass(h.op);
    m  = mnemonic(h.op, h.f3, h.f75);
    f1 = fwd(h.rs1, h.rs1d);
    f2 = fwd(h.rs2, h.rs2d);
    hz = h.valid && c == "LOAD" && h.rd != 0 && id_valid && (h.rd == id_rs1 || h.rd == id_rs2);
    checkOutput("rnd_ex_valid", 32'(ex_valid), 32'(h.valid));
    checkOutput("rnd_hazard", 32'(load_use_hazard), 32'(hz));
    if (!h.valid) begin
      checkOutput("rnd_bubble_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 32'd0);
    end else begin
      rw = !(c == "STORE" || c == "BR" || c == "UNK");
      checkOutput("rnd_regwrite", 32'(ex_regwrite), 32'(rw));
      checkOutput("rnd_memread", 32'(ex_memread), 32'(c == "LOAD"));
      checkOutput("rnd_memwrite", 32'(ex_memwrite), 32'(c == "STORE"));
      checkOutput("rnd_branch", 32'(ex_branch), 32'(c == "BR"));
      checkOutput("rnd_alu", 32'(ALU_control), 32'(code_tbl[m]));
      checkOutput("rnd_rd", 32'(ex_rd), 32'(h.rd));
      checkOutput("rnd_pc", ex_pc, h.pc);
      checkOutput("rnd_funct3", 32'(ex_funct3), 32'(h.f3));
      checkOutput("rnd_store_data", ex_store_data, f2);
      if (c != "UNK") begin
        if (c == "AUIPC" || c == "JAL") ea = h.pc;
        else if (c == "LUI") ea = 32'd0;
        else ea = f1;
        if (c == "I" || c == "LOAD" || c == "STORE" || c == "LUI" || c == "AUIPC") eb = h.imm;
        else if (c == "JAL" || c == "JALR") eb = 32'd4;
        else eb = f2;
        checkOutput("rnd_A", A, ea);
        checkOutput("rnd_B", B, eb);
      end
    end
  endtask

  function automatic instr_t randIns();
    instr_t i;
    i = mkIns(op_list[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
              5'($urandom_range(0, 3)), $urandom, $urandom);
    if (i.op == OPC_BRANCH && (i.f3 == 3'd2 || i.f3 == 3'd3)) i.f3 = i.f3 + 3'd4;
    if (i.op == OPC_OP && i.f3 != 3'd0 && i.f3 != 3'd5) i.f75 = 1'b0;
    i.valid = ($urandom_range(0, 7) != 0);
    return i;
  endfunction

  initial begin
    instr_t ri, nop;
    logic rs, st, fl;

    code_tbl["ADD"] = 5'b00000; code_tbl["SUB"] = 5'b00010; code_tbl["SLL"] = 5'b00100;
    code_tbl["SLT"] = 5'b01000; code_tbl["SLTU"] = 5'b01100; code_tbl["XOR"] = 5'b10000;
    code_tbl["SRL"] = 5'b10100; code_tbl["SRA"] = 5'b10110; code_tbl["OR"] = 5'b11000;
    code_tbl["AND"] = 5'b11100; code_tbl["BEQ"] = 5'b00010; code_tbl["BNE"] = 5'b00010;
    code_tbl["BLT"] = 5'b01000; code_tbl["BLTU"] = 5'b01100; code_tbl["BGE"] = 5'b11010;
    code_tbl["BGEU"] = 5'b11110; code_tbl["BXX"] = 5'b00000; code_tbl["LOAD"] = 5'b00000;
    code_tbl["STORE"] = 5'b00000; code_tbl["JAL"] = 5'b00000; code_tbl["JALR"] = 5'b00000;
    code_tbl["AUIPC"] = 5'b00000; code_tbl["LUI"] = 5'b11111; code_tbl["UNK"] = 5'b00000;

    vecs.push_back(mkVec("add", mkIns(OPC_OP, 3'd0, 1'b0, 5'd1, 32'd3, 5'd2, 32'd4, 5'd3, 32'd0, 32'h100),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'd3, 32'd4, 5'b00000, 1'b1, 1'b0));
    vecs.push_back(mkVec("addi_fwd", mkIns(OPC_OP_IMM, 3'd0, 1'b0, 5'd5, 32'd10, 5'd0, 32'd0, 5'd7, 32'd2, 32'h104),
                         5'd5, 1'b1, 32'd30, 5'd5, 1'b1, 32'd99, 1'b1, 32'd30, 32'd2, 5'b00000, 1'b1, 1'b0));
    vecs.push_back(mkVec("bge", mkIns(OPC_BRANCH, 3'd5, 1'b0, 5'd1, 32'd25, 5'd2, 32'd4, 5'd0, 32'd16, 32'h108),
                         5'd0, 1'b1, 32'd7, 5'd0, 1'b0, 32'd0, 1'b1, 32'd25, 32'd4, 5'b11010, 1'b0, 1'b1));
    vecs.push_back(mkVec("lui", mkIns(OPC_LUI, 3'd0, 1'b0, 5'd3, 32'd55, 5'd0, 32'd0, 5'd9, 32'h12345000, 32'h10C),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'd0, 32'h12345000, 5'b11111, 1'b1, 1'b0));
    vecs.push_back(mkVec("sub_memwb", mkIns(OPC_OP, 3'd0, 1'b1, 5'd1, 32'd20, 5'd2, 32'd5, 5'd4, 32'd0, 32'h110),
                         5'd0, 1'b0, 32'd0, 5'd2, 1'b1, 32'd8, 1'b1, 32'd20, 32'd8, 5'b00010, 1'b1, 1'b0));
    vecs.push_back(mkVec("sra", mkIns(OPC_OP, 3'd5, 1'b1, 5'd1, 32'hFFFFFFF0, 5'd2, 32'd2, 5'd4, 32'd0, 32'h114),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'hFFFFFFF0, 32'd2, 5'b10110, 1'b1, 1'b0));
    vecs.push_back(mkVec("sltiu", mkIns(OPC_OP_IMM, 3'd3, 1'b0, 5'd4, 32'd9, 5'd0, 32'd0, 5'd5, 32'd100, 32'h118),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'd9, 32'd100, 5'b01100, 1'b1, 1'b0));
    vecs.push_back(mkVec("bltu_fwd_prio", mkIns(OPC_BRANCH, 3'd6, 1'b0, 5'd3, 32'd1, 5'd4, 32'd2, 5'd0, 32'd8, 32'h11C),
                         5'd4, 1'b1, 32'd44, 5'd4, 1'b1, 32'd55, 1'b1, 32'd1, 32'd44, 5'b01100, 1'b0, 1'b1));
    vecs.push_back(mkVec("auipc", mkIns(OPC_AUIPC, 3'd0, 1'b0, 5'd1, 32'd7, 5'd0, 32'd0, 5'd6, 32'h2000, 32'h1000),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h1000, 32'h2000, 5'b00000, 1'b1, 1'b0));
    vecs.push_back(mkVec("jal", mkIns(OPC_JAL, 3'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'h100, 32'h40),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h40, 32'd4, 5'b00000, 1'b1, 1'b0));
    vecs.push_back(mkVec("jalr", mkIns(OPC_JALR, 3'd0, 1'b0, 5'd1, 32'h300, 5'd0, 32'd0, 5'd1, 32'd8, 32'h80),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'h300, 32'd4, 5'b00000, 1'b1, 1'b0));
    vecs.push_back(mkVec("addi_f7bit", mkIns(OPC_OP_IMM, 3'd0, 1'b1, 5'd2, 32'd5, 5'd0, 32'd0, 5'd3, 32'h400, 32'h120),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1, 32'd5, 32'h400, 5'b00000, 1'b1, 1'b0));
    vecs.push_back(mkVec("xor_x0_nofwd", mkIns(OPC_OP, 3'd4, 1'b0, 5'd0, 32'h0F, 5'd2, 32'hF0, 5'd3, 32'd0, 32'h124),
                         5'd0, 1'b1, 32'd77, 5'd0, 1'b1, 32'd88, 1'b1, 32'h0F, 32'hF0, 5'b10000, 1'b1, 1'b0));
    vecs.push_back(mkVec("unknown_op", mkIns(7'h7F, 3'd0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'd0, 32'h128),
                         5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 5'b00000, 1'b0, 1'b0));

    nop = '0;
    setForward(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    applyStimulus(nop, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_valid", 32'(ex_valid), 32'd0);
    checkOutput("reset_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 32'd0);
    checkOutput("reset_alu", 32'(ALU_control), 32'd0);
    checkOutput("reset_A", A, 32'd0);
    checkOutput("reset_B", B, 32'd0);
    checkOutput("reset_rd", 32'(ex_rd), 32'd0);
    checkOutput("reset_pc", ex_pc, 32'd0);

    foreach (vecs[k]) begin
      @(negedge CLK);
      applyStimulus(vecs[k].ins, 1'b0, 1'b0, 1'b0);
      setForward(vecs[k].xrd, vecs[k].xwe, vecs[k].xres, vecs[k].mrd, vecs[k].mwe, vecs[k].mres);
      @(posedge CLK);
      #1;
      checkOutput({vecs[k].name, "_valid"}, 32'(ex_valid), 32'd1);
      checkOutput({vecs[k].name, "_alu"}, 32'(ALU_control), 32'(vecs[k].exp_alu));
      checkOutput({vecs[k].name, "_regwrite"}, 32'(ex_regwrite), 32'(vecs[k].exp_rw));
      checkOutput({vecs[k].name, "_branch"}, 32'(ex_branch), 32'(vecs[k].exp_br));
      if (vecs[k].chk_ab) begin
        checkOutput({vecs[k].name, "_A"}, A, vecs[k].exp_a);
        checkOutput({vecs[k].name, "_B"}, B, vecs[k].exp_b);
      end
    end

    // Load-use: LW x6 in EX, dependent ADD in ID, two stall cycles, then flush+stall.
    @(negedge CLK);
    setForward(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    applyStimulus(mkIns(OPC_LOAD, 3'd2, 1'b0, 5'd1, 32'd100, 5'd0, 32'd0, 5'd6, 32'd8, 32'h20), 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    checkOutput("lw_memread", 32'(ex_memread), 32'd1);
    @(negedge CLK);
    applyStimulus(mkIns(OPC_OP, 3'd0, 1'b0, 5'd6, 32'd0, 5'd2, 32'd4, 5'd7, 32'd0, 32'h24), 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("lu_hazard", 32'(load_use_hazard), 32'd1);
    for (int s = 0; s < 2; s++) begin
      @(posedge CLK);
      #1;
      checkOutput("stall_valid", 32'(ex_valid), 32'd1);
      checkOutput("stall_rd", 32'(ex_rd), 32'd6);
      checkOutput("stall_A", A, 32'd100);
      checkOutput("stall_B", B, 32'd8);
      checkOutput("stall_memread", 32'(ex_memread), 32'd1);
      checkOutput("stall_pc", ex_pc, 32'h20);
      checkOutput("stall_hazard", 32'(load_use_hazard), 32'd1);
    end
    @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("flush_valid", 32'(ex_valid), 32'd0);
    checkOutput("flush_ctrl", {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_branch}, 32'd0);
    checkOutput("flush_hazard", 32'(load_use_hazard), 32'd0);

    // Reset arriving during a stall discards the held instruction.
    @(negedge CLK);
    applyStimulus(mkIns(OPC_OP, 3'd0, 1'b1, 5'd1, 32'd20, 5'd2, 32'd5, 5'd3, 32'd0, 32'h30), 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    checkOutput("pre_rst_alu", 32'(ALU_control), 32'b00010);
    @(negedge CLK);
    stall = 1'b1;
    RSTa  = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("rst_stall_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_stall_alu", 32'(ALU_control), 32'd0);
    checkOutput("rst_stall_A", A, 32'd0);
    checkOutput("rst_stall_B", B, 32'd0);

    // Random traffic: the model tracks the registered instruction at the mnemonic level.
    held = '0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (n > 0) checkModel(held);
      ri = randIns();
      rs = (n == 0) || ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      applyStimulus(ri, st, fl, rs);
      setForward(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      if (rs || fl || (!st && !ri.valid)) held_next = '0;
      else if (!st) held_next = ri;
      else held_next = held;
      @(posedge CLK);
      held = held_next;
    end
    @(negedge CLK);
    checkModel(held);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
